// File: rtl/sd_word_fifo_if.sv
// Word FIFO port bundle: write handshake, read port and occupancy status.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface sd_word_fifo_if #(
  parameter int DEPTH_LOG2 = 9
);
  logic                  fifo_write_request;
  logic [31:0]           fifo_write_data;
  logic                  fifo_request_finish;
  logic                  flush;
  logic                  rd_en;
  logic [31:0]           rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   level;
  logic                  block_room;

  modport slave (
    input  fifo_write_request, fifo_write_data, flush, rd_en,
    output fifo_request_finish, rd_data, rd_valid, empty, full, level, block_room
  );

  modport master (
    output fifo_write_request, fifo_write_data, flush, rd_en,
    input  fifo_request_finish, rd_data, rd_valid, empty, full, level, block_room
  );
endinterface

// File: rtl/sd_word_fifo.sv
// 32-bit word FIFO between the SD SPI host (request/finish handshake) and the
// transmit path (registered read port), with a block-room flag for SD block reads.
module sd_word_fifo #(
  parameter int DEPTH_LOG2  = 9,
  parameter int BLOCK_WORDS = 128
) (
  input  logic           clk,
  input  logic           rst,
  sd_word_fifo_if.slave  bus
);
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] ROOM_MAX   = (DEPTH_LOG2+1)'((1 << DEPTH_LOG2) - BLOCK_WORDS);

  logic [31:0]         mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wptr;
  logic [DEPTH_LOG2:0] rptr;
  logic [DEPTH_LOG2:0] count;
  logic                finish;
  logic                rd_valid;
  logic [31:0]         rd_data;
  logic                empty;
  logic                full;
  logic                wr_acc;
  logic                rd_acc;

  // Status comes from registered pointers only; wrap bit makes full/empty distinct.
  always_comb begin
    count = wptr - rptr;
    empty = (count == '0);
    full  = (count == FULL_LEVEL);
  end

  // finish masks the cycle where the producer still holds request after acceptance.
  assign wr_acc = bus.fifo_write_request && !finish && !full && !bus.flush;
  assign rd_acc = bus.rd_en && !empty && !bus.flush;

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wptr[DEPTH_LOG2-1:0]] <= bus.fifo_write_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      finish   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (bus.flush) begin
      wptr     <= '0;
      rptr     <= '0;
      finish   <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      finish   <= wr_acc;
      rd_valid <= rd_acc;
      if (wr_acc)
        wptr <= wptr + 1'b1;
      if (rd_acc) begin
        rd_data <= mem[rptr[DEPTH_LOG2-1:0]];
        rptr    <= rptr + 1'b1;
      end
    end
  end

  assign bus.fifo_request_finish = finish;
  assign bus.rd_valid            = rd_valid;
  assign bus.rd_data             = rd_data;
  assign bus.empty               = empty;
  assign bus.full                = full;
  assign bus.level               = count;
  assign bus.block_room          = (count <= ROOM_MAX);
endmodule
